// File: rtl/kamacore_lsu.sv
// Load/store unit between an RV32I core and a word-wide asynchronous-read memory.
// Handles byte/halfword lane extraction on loads and read-modify-write merging on stores.
module kamacore_lsu #(
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int CPU_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // valid/ready: a transfer happens on a posedge where valid && ready; valid holds its payload until then.
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [CPU_WIDTH-1:0]      req_addr,
  input  logic [CPU_WIDTH-1:0]      req_wdata,
  input  logic [4:0]                req_rd,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [CPU_WIDTH-1:0]      rsp_data,
  output logic [4:0]                rsp_rd,
  output logic                      rsp_err,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a,
  output logic [CPU_WIDTH-1:0]      mem_di,
  input  logic [CPU_WIDTH-1:0]      mem_spo,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                    r_state;
  logic [2:0]                r_funct3;
  logic [MEM_ADDR_WIDTH+1:0] r_addr;
  logic [CPU_WIDTH-1:0]      r_wdata;
  logic [CPU_WIDTH-1:0]      r_rsp_data;
  logic [4:0]                r_rsp_rd;
  logic                      r_rsp_err;

  logic                      w_f3_ok;
  logic                      w_misal;
  logic                      w_err;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;
  logic [CPU_WIDTH-1:0]      w_load_data;
  logic [3:0]                w_mask;
  logic [CPU_WIDTH-1:0]      w_wrep;
  logic [CPU_WIDTH-1:0]      w_merged;
  logic                      w_unused;

  // Upper address bits are deliberately dropped so the word index wraps.
  assign w_unused = ^req_addr[CPU_WIDTH-1:MEM_ADDR_WIDTH+2];

  always_comb begin
    w_f3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = ~req_we;
      default:                w_f3_ok = 1'b0;
    endcase
    w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_err   = ~w_f3_ok | w_misal;
  end

  always_comb begin
    w_byte      = mem_spo[{r_addr[1:0], 3'b000} +: 8];
    w_half      = r_addr[1] ? mem_spo[31:16] : mem_spo[15:0];
    w_load_data = mem_spo;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_spo;
    endcase
  end

  // Store data is replicated across lanes, then the byte mask picks which lanes replace the old word.
  always_comb begin
    w_mask = 4'b1111;
    w_wrep = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_mask = 4'b0001 << r_addr[1:0];
        w_wrep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_mask = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_mask = 4'b1111;
        w_wrep = r_wdata;
      end
    endcase
    w_merged = mem_spo;
    for (int i = 0; i < 4; i++) begin
      w_merged[8*i +: 8] = w_mask[i] ? w_wrep[8*i +: 8] : mem_spo[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_funct3   <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_rsp_rd   <= 5'd0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3   <= req_funct3;
            r_addr     <= req_addr[MEM_ADDR_WIDTH+1:0];
            r_wdata    <= req_wdata;
            r_rsp_rd   <= req_rd;
            r_rsp_data <= '0;
            r_rsp_err  <= w_err;
            if (w_err)       r_state <= S_RESP;
            else if (req_we) r_state <= S_STORE;
            else             r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_rsp_data <= w_load_data;
          r_state    <= S_RESP;
        end
        S_STORE: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from state so reset clears them immediately.
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_rd    = r_rsp_rd;
  assign rsp_err   = r_rsp_err;
  assign mem_we    = (r_state == S_STORE);
  assign mem_a     = ((r_state == S_LOAD) || (r_state == S_STORE)) ? r_addr[MEM_ADDR_WIDTH+1:2] : '0;
  assign mem_di    = (r_state == S_STORE) ? w_merged : '0;
  assign dbg_state = r_state;

endmodule
